// File: rtl/pc_seq_pkg.sv
// pc_seq_pkg: shared encodings and default vectors for the PC sequencer.
// Latency: n/a (types, constants and one pure function).
// Backpressure: n/a.
package pc_seq_pkg;

  typedef enum logic [1:0] {
    RUN  = 2'd0,
    HOLD = 2'd1,
    PEND = 2'd2
  } pc_state_e;

  // Next-PC source select codes
  typedef enum logic [2:0] {
    SRC_SEQ  = 3'd0,
    SRC_BR   = 3'd1,
    SRC_JMP  = 3'd2,
    SRC_JR   = 3'd3,
    SRC_ERET = 3'd4,
    SRC_EXC  = 3'd5
  } pc_src_e;

  localparam logic [31:0] RESET_VEC_DEF = 32'hBFC00000;
  localparam logic [31:0] EXC_VEC_DEF   = 32'hBFC00380;

  // Fixed request priority; lower-priority requests are simply dropped.
  function automatic pc_src_e pc_src_sel(input logic exc, input logic eret,
                                         input logic jr, input logic jmp,
                                         input logic br);
    if (exc)       return SRC_EXC;
    else if (eret) return SRC_ERET;
    else if (jr)   return SRC_JR;
    else if (jmp)  return SRC_JMP;
    else if (br)   return SRC_BR;
    else           return SRC_SEQ;
  endfunction

endpackage

// File: rtl/pc_seq_if.sv
// pc_seq_if: control-side request bus and fetch-address results of pc_seq.
// master = decode/execute control driving requests, slave = pc_seq.
// Optional PC_ALIGN_CHECK_EN adds BadVAddr_O / AlignErr_O.
interface pc_seq_if #(
  parameter int ADDR_W = 32
);
  logic              Stall_I;
  logic              Branch_I;
  logic [15:0]       BrOff_I;
  logic              Jump_I;
  logic [25:0]       Target_I;
  logic              JumpReg_I;
  logic [ADDR_W-1:0] RegAddr_I;
  logic              Exc_I;
  logic [ADDR_W-1:0] ExcPC_I;
  logic              Eret_I;
  logic [ADDR_W-1:0] PC_O;
  logic [ADDR_W-1:0] EPC_O;
  logic              Pending_O;
`ifdef PC_ALIGN_CHECK_EN
  logic [ADDR_W-1:0] BadVAddr_O;
  logic              AlignErr_O;
`endif

  modport master (
    output Stall_I, Branch_I, BrOff_I, Jump_I, Target_I, JumpReg_I, RegAddr_I,
           Exc_I, ExcPC_I, Eret_I,
`ifdef PC_ALIGN_CHECK_EN
    input  BadVAddr_O, AlignErr_O,
`endif
    input  PC_O, EPC_O, Pending_O
  );

  modport slave (
    input  Stall_I, Branch_I, BrOff_I, Jump_I, Target_I, JumpReg_I, RegAddr_I,
           Exc_I, ExcPC_I, Eret_I,
`ifdef PC_ALIGN_CHECK_EN
    output BadVAddr_O, AlignErr_O,
`endif
    output PC_O, EPC_O, Pending_O
  );

endinterface

// File: rtl/pc_target_calc.sv
// pc_target_calc: computes every next-PC candidate from the current PC/EPC.
// Latency: combinational. Backpressure: none.
// Ports: pc/epc/br_off/jmp_idx/reg_addr in; one target per source out.
module pc_target_calc #(
  parameter int          ADDR_W  = 32,
  parameter logic [31:0] EXC_VEC = pc_seq_pkg::EXC_VEC_DEF
) (
  input  logic [ADDR_W-1:0] pc,
  input  logic [ADDR_W-1:0] epc,
  input  logic [15:0]       br_off,
  input  logic [25:0]       jmp_idx,
  input  logic [ADDR_W-1:0] reg_addr,
  output logic [ADDR_W-1:0] seq_tgt,
  output logic [ADDR_W-1:0] br_tgt,
  output logic [ADDR_W-1:0] jmp_tgt,
  output logic [ADDR_W-1:0] jr_tgt,
  output logic [ADDR_W-1:0] eret_tgt,
  output logic [ADDR_W-1:0] exc_tgt
);

  // Word offset sign-extended and turned into a byte offset.
  logic [ADDR_W-1:0] br_off_ext;
  assign br_off_ext = {{(ADDR_W-18){br_off[15]}}, br_off, 2'b00};

  // All sums are ADDR_W wide, so they wrap at the top of the address space.
  assign seq_tgt  = pc + ADDR_W'(4);
  assign br_tgt   = pc + ADDR_W'(4) + br_off_ext;
  assign jmp_tgt  = {pc[ADDR_W-1:28], jmp_idx, 2'b00};
  assign jr_tgt   = reg_addr;
  assign eret_tgt = epc;
  assign exc_tgt  = ADDR_W'(EXC_VEC);

endmodule

// File: rtl/pc_seq.sv
// pc_seq: PC register, next-PC priority select, EPC and one buffered redirect.
// Latency: one cycle request -> PC_O. Stall_I holds PC; one redirect is
// latched while stalled (youngest wins); Exc_I is never held off by Stall_I.
// Ports: CLK_I, Reset_I (sync active-low), bus (pc_seq_if.slave).
// Optional macro PC_ALIGN_CHECK_EN: misaligned targets become exceptions.
module pc_seq
  import pc_seq_pkg::*;
#(
  parameter int          ADDR_W    = 32,
  parameter logic [31:0] RESET_VEC = RESET_VEC_DEF,
  parameter logic [31:0] EXC_VEC   = EXC_VEC_DEF
) (
  input logic   CLK_I,
  input logic   Reset_I,
  pc_seq_if.slave bus
);

  localparam logic [ADDR_W-1:0] RST_V = ADDR_W'(RESET_VEC);

  pc_state_e         state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] epc_q, epc_d;
  logic [ADDR_W-1:0] tgt_q, tgt_d;
`ifdef PC_ALIGN_CHECK_EN
  logic [ADDR_W-1:0] bad_q, bad_d;
  logic              aerr_q, aerr_d;
`endif

  logic [ADDR_W-1:0] seq_tgt, br_tgt, jmp_tgt, jr_tgt, eret_tgt, exc_tgt;
  pc_src_e           src;
  logic [ADDR_W-1:0] sel_tgt;
  logic              redir;
  logic              apply, latch;
  logic [ADDR_W-1:0] upd_tgt;

  pc_target_calc #(
    .ADDR_W (ADDR_W),
    .EXC_VEC(EXC_VEC)
  ) u_calc (
    .pc      (pc_q),
    .epc     (epc_q),
    .br_off  (bus.BrOff_I),
    .jmp_idx (bus.Target_I),
    .reg_addr(bus.RegAddr_I),
    .seq_tgt (seq_tgt),
    .br_tgt  (br_tgt),
    .jmp_tgt (jmp_tgt),
    .jr_tgt  (jr_tgt),
    .eret_tgt(eret_tgt),
    .exc_tgt (exc_tgt)
  );

  assign redir = bus.Eret_I | bus.JumpReg_I | bus.Jump_I | bus.Branch_I;
  assign src   = pc_src_sel(bus.Exc_I, bus.Eret_I, bus.JumpReg_I, bus.Jump_I,
                            bus.Branch_I);

  always_comb begin
    sel_tgt = seq_tgt;
    case (src)
      SRC_BR:   sel_tgt = br_tgt;
      SRC_JMP:  sel_tgt = jmp_tgt;
      SRC_JR:   sel_tgt = jr_tgt;
      SRC_ERET: sel_tgt = eret_tgt;
      SRC_EXC:  sel_tgt = exc_tgt;
      default:  sel_tgt = seq_tgt;
    endcase
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    epc_d   = epc_q;
    tgt_d   = tgt_q;
    apply   = 1'b0;
    latch   = 1'b0;
    upd_tgt = sel_tgt;
`ifdef PC_ALIGN_CHECK_EN
    bad_d   = bad_q;
    aerr_d  = 1'b0;
`endif

    if (bus.Exc_I) begin
      // Exceptions bypass the stall and flush any buffered redirect.
      pc_d    = exc_tgt;
      epc_d   = bus.ExcPC_I;
      state_d = RUN;
    end else begin
      case (state_q)
        PEND: begin
          if (!bus.Stall_I) begin
            // Release the buffered target; this cycle's requests are dropped.
            apply   = 1'b1;
            upd_tgt = tgt_q;
            state_d = RUN;
          end else if (redir) begin
            latch = 1'b1;
          end
        end
        default: begin  // RUN and HOLD share the same per-cycle behaviour
          if (!bus.Stall_I) begin
            apply   = 1'b1;
            state_d = RUN;
          end else if (redir) begin
            latch   = 1'b1;
            state_d = PEND;
          end else begin
            state_d = HOLD;
          end
        end
      endcase
    end

`ifdef PC_ALIGN_CHECK_EN
    if ((apply || latch) && (upd_tgt[1:0] != 2'b00)) begin
      // Misaligned target turns into an exception blamed on the current PC.
      pc_d    = exc_tgt;
      epc_d   = pc_q;
      bad_d   = upd_tgt;
      aerr_d  = 1'b1;
      state_d = RUN;
    end else begin
      if (apply) pc_d = upd_tgt;
      if (latch) tgt_d = upd_tgt;
    end
`else
    if (apply) pc_d = upd_tgt;
    if (latch) tgt_d = upd_tgt;
`endif
  end

  always_ff @(posedge CLK_I) begin
    if (!Reset_I) begin
      state_q <= RUN;
      pc_q    <= RST_V;
      epc_q   <= '0;
      tgt_q   <= '0;
`ifdef PC_ALIGN_CHECK_EN
      bad_q   <= '0;
      aerr_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      epc_q   <= epc_d;
      tgt_q   <= tgt_d;
`ifdef PC_ALIGN_CHECK_EN
      bad_q   <= bad_d;
      aerr_q  <= aerr_d;
`endif
    end
  end

  assign bus.PC_O      = pc_q;
  assign bus.EPC_O     = epc_q;
  assign bus.Pending_O = (state_q == PEND);
`ifdef PC_ALIGN_CHECK_EN
  assign bus.BadVAddr_O = bad_q;
  assign bus.AlignErr_O = aerr_q;
`endif

endmodule

// File: tb/tb_pc_seq.sv
// tb_pc_seq: directed vector table plus hand-written multi-cycle sequences.
// Inputs change on the falling edge; outputs are compared 1 time unit after
// the rising edge that consumed them.
module tb_pc_seq;

  typedef enum int {OP_NONE, OP_BR, OP_J, OP_JR, OP_ERET, OP_EXCJR,
                    OP_ALL, OP_ERETJR, OP_EXCERET} op_e;

  typedef struct {
    string       nm;
    logic        rst;
    logic        stall;
    op_e         op;
    logic [31:0] a;
    logic [31:0] e_pc;
    logic [31:0] e_epc;
    logic        e_pend;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   failures = 0;
  vec_t tbl[$];

  pc_seq_if #(.ADDR_W(32)) bus ();

  pc_seq #(.ADDR_W(32)) dut (
    .CLK_I  (clk),
    .Reset_I(rst_n),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic step(input logic rst, input logic stall, input op_e op,
                      input logic [31:0] a);
    @(negedge clk);
    rst_n         = rst;
    bus.Stall_I   = stall;
    bus.Branch_I  = 1'b0;
    bus.BrOff_I   = 16'h0;
    bus.Jump_I    = 1'b0;
    bus.Target_I  = 26'h0;
    bus.JumpReg_I = 1'b0;
    bus.RegAddr_I = 32'h0;
    bus.Exc_I     = 1'b0;
    bus.ExcPC_I   = 32'h0;
    bus.Eret_I    = 1'b0;
    case (op)
      OP_BR:    begin bus.Branch_I = 1'b1; bus.BrOff_I = a[15:0]; end
      OP_J:     begin bus.Jump_I = 1'b1; bus.Target_I = a[25:0]; end
      OP_JR:    begin bus.JumpReg_I = 1'b1; bus.RegAddr_I = a; end
      OP_ERET:  bus.Eret_I = 1'b1;
      OP_EXCJR: begin
        bus.Exc_I = 1'b1; bus.ExcPC_I = a;
        bus.JumpReg_I = 1'b1; bus.RegAddr_I = 32'h80006000;
      end
      OP_ALL: begin
        bus.JumpReg_I = 1'b1; bus.RegAddr_I = a;
        bus.Jump_I = 1'b1; bus.Target_I = 26'h0;
        bus.Branch_I = 1'b1; bus.BrOff_I = 16'h0001;
      end
      OP_ERETJR:   begin bus.Eret_I = 1'b1; bus.JumpReg_I = 1'b1; bus.RegAddr_I = a; end
      OP_EXCERET:  begin bus.Exc_I = 1'b1; bus.ExcPC_I = a; bus.Eret_I = 1'b1; end
      default: ;
    endcase
    @(posedge clk);
    #1;
  endtask

  task automatic add(input string nm, input logic rst, input logic stall, input op_e op,
                     input logic [31:0] a, input logic [31:0] e_pc,
                     input logic [31:0] e_epc, input logic e_pend);
    vec_t v;
    v.nm = nm; v.rst = rst; v.stall = stall; v.op = op; v.a = a;
    v.e_pc = e_pc; v.e_epc = e_epc; v.e_pend = e_pend;
    tbl.push_back(v);
  endtask

  initial begin
    bus.Stall_I = 1'b0; bus.Branch_I = 1'b0; bus.BrOff_I = '0; bus.Jump_I = 1'b0;
    bus.Target_I = '0; bus.JumpReg_I = 1'b0; bus.RegAddr_I = '0; bus.Exc_I = 1'b0;
    bus.ExcPC_I = '0; bus.Eret_I = 1'b0;

    //   name        rst  stall op          arg           PC            EPC           pend
    add("rst0",      0, 0, OP_NONE,    32'h0,        32'hBFC00000, 32'h0,        0);
    add("rst1",      0, 0, OP_NONE,    32'h0,        32'hBFC00000, 32'h0,        0);
    add("seq1",      1, 0, OP_NONE,    32'h0,        32'hBFC00004, 32'h0,        0);
    add("seq2",      1, 0, OP_NONE,    32'h0,        32'hBFC00008, 32'h0,        0);
    add("seq3",      1, 0, OP_NONE,    32'h0,        32'hBFC0000C, 32'h0,        0);
    add("seq4",      1, 0, OP_NONE,    32'h0,        32'hBFC00010, 32'h0,        0);
    add("br_neg",    1, 0, OP_BR,      32'hFFFE,     32'hBFC0000C, 32'h0,        0);
    add("seq5",      1, 0, OP_NONE,    32'h0,        32'hBFC00010, 32'h0,        0);
    add("jmp",       1, 0, OP_J,       32'h40,       32'hB0000100, 32'h0,        0);
    add("jr",        1, 0, OP_JR,      32'hBFC0001C, 32'hBFC0001C, 32'h0,        0);
    add("seq6",      1, 0, OP_NONE,    32'h0,        32'hBFC00020, 32'h0,        0);
    add("st_jmp",    1, 1, OP_J,       32'h40,       32'hBFC00020, 32'h0,        1);
    add("st_jr",     1, 1, OP_JR,      32'h80001000, 32'hBFC00020, 32'h0,        1);
    add("release",   1, 0, OP_NONE,    32'h0,        32'h80001000, 32'h0,        0);
    add("hold",      1, 1, OP_NONE,    32'h0,        32'h80001000, 32'h0,        0);
    add("hold_br",   1, 1, OP_BR,      32'h0004,     32'h80001000, 32'h0,        1);
    add("exc_pend",  1, 1, OP_EXCJR,   32'hBFC00044, 32'hBFC00380, 32'hBFC00044, 0);
    add("seq7",      1, 0, OP_NONE,    32'h0,        32'hBFC00384, 32'hBFC00044, 0);
    add("eret",      1, 0, OP_ERET,    32'h0,        32'hBFC00044, 32'hBFC00044, 0);
    add("hold2",     1, 1, OP_NONE,    32'h0,        32'hBFC00044, 32'hBFC00044, 0);
    add("hold_jmp",  1, 0, OP_J,       32'h3FFFFFF,  32'hBFFFFFFC, 32'hBFC00044, 0);
    add("st_jr2",    1, 1, OP_JR,      32'h80002000, 32'hBFFFFFFC, 32'hBFC00044, 1);
    add("rel_ign",   1, 0, OP_J,       32'h0,        32'h80002000, 32'hBFC00044, 0);
    add("jr_top",    1, 0, OP_JR,      32'hFFFFFFFC, 32'hFFFFFFFC, 32'hBFC00044, 0);
    add("wrap",      1, 0, OP_NONE,    32'h0,        32'h00000000, 32'hBFC00044, 0);
    add("prio_jr",   1, 0, OP_ALL,     32'h80003000, 32'h80003000, 32'hBFC00044, 0);
    add("prio_eret", 1, 0, OP_ERETJR,  32'h80004000, 32'hBFC00044, 32'hBFC00044, 0);
    add("exc_eret",  1, 0, OP_EXCERET, 32'h12345678, 32'hBFC00380, 32'h12345678, 0);
    add("st_pend",   1, 1, OP_JR,      32'h80005000, 32'hBFC00380, 32'h12345678, 1);
    add("rst_pend",  0, 1, OP_JR,      32'h80005000, 32'hBFC00000, 32'h0,        0);

    foreach (tbl[i]) begin
      step(tbl[i].rst, tbl[i].stall, tbl[i].op, tbl[i].a);
      chk({tbl[i].nm, ".pc"},   bus.PC_O,              tbl[i].e_pc);
      chk({tbl[i].nm, ".epc"},  bus.EPC_O,             tbl[i].e_epc);
      chk({tbl[i].nm, ".pend"}, {31'b0, bus.Pending_O}, {31'b0, tbl[i].e_pend});
    end

    // Youngest buffered redirect wins; a quiet stall cycle keeps it pending.
    step(1, 0, OP_NONE, 32'h0);
    chk("yw.seq", bus.PC_O, 32'hBFC00004);
    step(1, 1, OP_JR, 32'h80007000);
    chk("yw.jr.pend", {31'b0, bus.Pending_O}, 32'h1);
    step(1, 1, OP_BR, 32'h0010);
    chk("yw.br.pc", bus.PC_O, 32'hBFC00004);
    step(1, 1, OP_NONE, 32'h0);
    chk("yw.idle.pend", {31'b0, bus.Pending_O}, 32'h1);
    step(1, 0, OP_NONE, 32'h0);
    chk("yw.rel.pc", bus.PC_O, 32'hBFC00048);
    chk("yw.rel.pend", {31'b0, bus.Pending_O}, 32'h0);

`ifdef PC_ALIGN_CHECK_EN
    step(0, 0, OP_NONE, 32'h0);
    step(0, 0, OP_NONE, 32'h0);
    chk("al.rst.bad", bus.BadVAddr_O, 32'h0);
    chk("al.rst.err", {31'b0, bus.AlignErr_O}, 32'h0);
    step(1, 0, OP_NONE, 32'h0);
    step(1, 0, OP_NONE, 32'h0);
    chk("al.pre.pc", bus.PC_O, 32'hBFC00008);
    step(1, 0, OP_JR, 32'h80000002);
    chk("al.pc",  bus.PC_O, 32'hBFC00380);
    chk("al.epc", bus.EPC_O, 32'hBFC00008);
    chk("al.bad", bus.BadVAddr_O, 32'h80000002);
    chk("al.err", {31'b0, bus.AlignErr_O}, 32'h1);
    step(1, 0, OP_NONE, 32'h0);
    chk("al.err_pulse", {31'b0, bus.AlignErr_O}, 32'h0);
    chk("al.next.pc", bus.PC_O, 32'hBFC00384);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pc_seq.md
Name: pc_seq

Overview:
- Parametrised program-counter sequencer; successor to the single-register PC and its jump-address helper.
- Owns the PC register, the next-PC selection (sequential, branch, jump, jump-register, exception, return-from-exception) and the EPC register.
- Buffers one redirect that arrives while fetch is stalled.
- Sits between the decode/execute control and the instruction-fetch address port.

Parameters:
- ADDR_W, 32, PC/address width; must be at least 29.
- RESET_VEC, 32'hBFC00000, PC value after reset; truncated to ADDR_W.
- EXC_VEC, 32'hBFC00380, exception entry address; truncated to ADDR_W.

Ports:
- CLK_I  in  1  system clock; all state changes on its rising edge.
- Reset_I  in  1  synchronous, active-low reset.
- Stall_I  in  1  hold PC (fetch stall).
- Branch_I  in  1  taken conditional branch.
- BrOff_I  in  16  branch word offset, signed.
- Jump_I  in  1  absolute jump.
- Target_I  in  26  jump instruction index.
- JumpReg_I  in  1  register jump.
- RegAddr_I  in  ADDR_W  register jump target.
- Exc_I  in  1  exception request.
- ExcPC_I  in  ADDR_W  faulting instruction address.
- Eret_I  in  1  return from exception.
- PC_O  out  ADDR_W  current fetch address.
- EPC_O  out  ADDR_W  saved exception PC.
- Pending_O  out  1  buffered redirect is held.

Behaviour:
- Reset (Reset_I=0 at a rising edge):
  - PC_O=RESET_VEC, EPC_O=0, Pending_O=0, state RUN.
  - Reset overrides every other input, including mid-stall with a redirect pending.
- Next-PC target per event (base = PC_O, modulo 2^ADDR_W):
  - sequential: PC_O+4
  - branch: PC_O+4+(sext(BrOff_I)<<2)
  - jump: {PC_O[ADDR_W-1:28], Target_I, 2'b00}
  - jump-register: RegAddr_I
  - eret: EPC_O
  - exception: EXC_VEC
- Priority: Exc_I > Eret_I > JumpReg_I > Jump_I > Branch_I > sequential. Lower-priority requests in the same cycle are discarded.
- Exc_I:
  - Always takes effect at the next edge, regardless of Stall_I.
  - EPC_O<=ExcPC_I, PC_O<=EXC_VEC, pending cleared, state RUN.
  - Exc_I with Eret_I in the same cycle: exception wins and EPC is updated.
- Latency: one cycle from request to new PC_O.
- States: RUN, HOLD, PEND.
  - RUN, Stall_I=0: PC_O<=selected target.
  - RUN, Stall_I=1, no redirect: PC holds, go to HOLD.
  - RUN, Stall_I=1 with a non-exception redirect: PC holds, target latched, Pending_O=1, go to PEND.
  - HOLD, Stall_I=1: PC holds. A redirect latches it and goes to PEND.
  - HOLD, Stall_I=0: behaves as RUN for that cycle's inputs, then go to RUN.
  - PEND, Stall_I=1: PC holds. A new non-exception redirect replaces the latched target (youngest wins).
  - PEND, Stall_I=0: PC_O<=latched target, pending cleared, go to RUN. All non-exception requests that cycle are ignored.
- Arithmetic: all adders are ADDR_W wide; carry out is dropped (wrap at top of address space, no flag).

Optional Feature:
- Macro: PC_ALIGN_CHECK_EN.
- With the macro:
  - Adds outputs BadVAddr_O (ADDR_W) and AlignErr_O (1).
  - Any applied or latched target with bits [1:0]!=0 is converted into an exception.
  - For that exception: EPC_O<=PC_O, BadVAddr_O<=bad target, PC_O<=EXC_VEC, AlignErr_O pulses high for one cycle.
  - Reset values are 0.
- Without the macro: ports are absent and targets are used unchecked.

Decomposition:
- Shared package holds:
  - the state encoding (RUN=2'd0, HOLD=2'd1, PEND=2'd2);
  - the next-PC source select codes;
  - the default RESET_VEC and EXC_VEC constants.
- One sub-module, pc_target_calc: combinational, computes all target candidates from PC_O and the inputs.
- The top level holds the priority select, the FSM, the pending register and EPC.

Test Plan:
- Reset_I=0 for 2 cycles, then 1 -> PC_O=BFC00000, then BFC00004, BFC00008 on successive edges.
- PC=BFC00010, Branch_I, BrOff_I=16'hFFFE -> PC_O=BFC0000C; Jump_I with Target_I=26'h0000040 and PC=BFC00010 -> PC_O=B0000100.
- Stall_I=1 at PC=BFC00020, Jump_I pulse, then JumpReg_I RegAddr_I=80001000 while stalled -> Pending_O=1, PC held; Stall_I=0 -> PC_O=80001000, Pending_O=0.
- Stall_I=1 with a pending redirect, Exc_I with ExcPC_I=BFC00044 -> PC_O=BFC00380, EPC_O=BFC00044, Pending_O=0; later Eret_I -> PC_O=BFC00044.
- Exc_I and Eret_I same cycle, ExcPC_I=12345678 -> PC_O=BFC00380, EPC_O=12345678; Reset_I=0 while PEND -> Pending_O=0, PC_O=BFC00000.
- PC_ALIGN_CHECK_EN: JumpReg_I RegAddr_I=80000002 at PC=BFC00008 -> PC_O=BFC00380, EPC_O=BFC00008, BadVAddr_O=80000002, AlignErr_O one-cycle pulse.
